dump_sequencer: RTL and testbench
=================================

// Module: dump_sequencer
// PURPOSE
//  Sequences a channel dump after Command_Config pulses `dump`.
//  Each dump runs in two phases:
//  - Calibration: reads offset and gain for (dump_ch, chX_AFEgain) from the calibration EEPROM over SPI,
//    pulsing flopOffset/flopGain when EEP_data is valid.
//  - Sample stream: walks the circular capture RAM oldest-to-newest, pushing each corrected sample out the UART.
//  Sits beside Command_Config. Top level muxes SPI (wrt_SPI/SPI_data/ss) and send_resp onto this block while dump_busy=1.
// PARAMETERS
//  ENTRIES  384  capture RAM depth (samples per channel)
//  ADDR_W   9    RAM address width; must satisfy 2**ADDR_W >= ENTRIES
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       async active-low reset
//  dump         in   1       1-cycle start pulse
//  dump_ch      in   2       channel to dump: 00=ch1, 01=ch2, 10=ch3, 11=reserved
//  ch1_AFEgain  in   3       current gain setting, ch1
//  ch2_AFEgain  in   3       current gain setting, ch2
//  ch3_AFEgain  in   3       current gain setting, ch3
//  trig_addr    in   ADDR_W  RAM address of newest captured sample
//  SPI_done     in   1       SPI transaction complete (1-cycle pulse)
//  resp_sent    in   1       UART byte transmitted (1-cycle pulse)
//  wrt_SPI      out  1       start SPI transaction (1-cycle pulse)
//  SPI_data     out  16      SPI word
//  ss           out  3       slave select; always 3'b100 (EEPROM)
//  flopOffset   out  1       EEP_data holds offset this cycle
//  flopGain     out  1       EEP_data holds gain this cycle
//  ram_addr     out  ADDR_W  capture RAM read address
//  send_resp    out  1       UART send request (1-cycle pulse)
//  dump_busy    out  1       high from the cycle after dump until return to IDLE
//  dump_done    out  1       1-cycle pulse on completion
// BEHAVIOUR
//  Reset values: all outputs 0 except ss=3'b100, SPI_data=16'h0000; FSM=IDLE.
//  Reset mid-dump aborts immediately to IDLE; no done pulse.
//  EEPROM address: cal_addr[5:0] = {dump_ch, gain_sel, sel}, sel 0=offset, 1=gain.
//  EEPROM read = two SPI transactions:
//    1. {2'b00, cal_addr, 8'h00}
//    2. dummy 16'hBCBC; EEP_data is valid in the cycle its SPI_done arrives.
//  FSM states: IDLE, OFF_CMD, OFF_RD, GAIN_CMD, GAIN_RD, RAM_RD, SEND, WAIT_TX, DONE.
//  - IDLE: dump -> latch dump_ch and gain_sel; addr = (trig_addr==ENTRIES-1) ? 0 : trig_addr+1; cnt=0.
//    Then go to OFF_CMD; if dump_ch==11, go straight to DONE.
//  - OFF_CMD: wrt_SPI=1 with transaction 1 word -> OFF_RD.
//  - OFF_RD: SPI_done -> wrt_SPI with 16'hBCBC. Next SPI_done -> flopOffset=1 -> GAIN_CMD.
//  - GAIN_CMD / GAIN_RD: same sequence with sel=1; ends with flopGain=1 -> RAM_RD.
//  - RAM_RD: drive ram_addr, wait 1 cycle (RAM read plus gain correction settle) -> SEND.
//  - SEND: send_resp=1 for one cycle -> WAIT_TX.
//  - WAIT_TX: on resp_sent:
//      if cnt==ENTRIES-1 -> DONE;
//      else addr wraps ENTRIES-1 -> 0, cnt++ -> RAM_RD.
//    resp_sent seen in any other state is ignored.
//  - DONE: dump_done=1 for one cycle -> IDLE.
//  Exactly ENTRIES bytes per dump; the last byte sent is from trig_addr.
//  dump asserted while busy is ignored; the latched dump_ch/gain_sel are not disturbed.
//  Per-sample latency: 2 cycles plus the UART time.
// CONFIGURATION
//  DUMP_CAL_CACHE_EN:
//  - Defined: keep {valid, dump_ch, gain_sel} from the last completed calibration phase.
//    A dump matching the cached tuple skips OFF_*/GAIN_* and goes IDLE -> RAM_RD with no SPI activity.
//    Cache valid clears on reset and on an aborted calibration phase.
//  - Undefined: every dump performs both EEPROM reads.
// STRUCTURE
//  dump_pkg:
//  - state_t enum
//  - EEP_RD_CMD = 2'b00
//  - EEP_DUMMY = 16'hBCBC
//  - SS_EEP = 3'b100
//  - CH_RSVD = 2'b11
//  Sub-module circ_addr_ctr: ADDR_W-bit load/increment with wrap at ENTRIES-1.
//  The FSM and the sample counter stay in dump_sequencer.
// TESTING
//  1. dump, dump_ch=01, ch2_AFEgain=3'b101:
//     SPI words 16'h1A00, BCBC, 16'h1B00, BCBC in order;
//     flopOffset, then flopGain, each pulsed once.
//  2. trig_addr=383: ram_addr sequence 0..383; 384 send_resp pulses; one dump_done.
//  3. trig_addr=100: ram_addr sequence 101..383, 0..100; cnt wraps correctly.
//  4. dump_ch=11: no wrt_SPI, no send_resp; dump_done 2 cycles after dump.
//  5. Second dump pulse mid-stream: ignored, byte count still 384.
//     rst_n low mid-stream: all outputs return to reset values.
//  6. DUMP_CAL_CACHE_EN: two identical dumps -> 4 SPI transactions total.
//     Change ch1 gain -> 4 more on the next dump.

Source files
------------

// File: rtl/dump_pkg.sv
// Shared types and constants for the channel dump sequencer.
package dump_pkg;

  typedef enum logic [3:0] {
    StIdle, StOffCmd, StOffRd, StGainCmd, StGainRd, StRamRd, StSend, StWaitTx, StDone
  } state_t;

  localparam logic [1:0]  EEP_RD_CMD = 2'b00;
  localparam logic [15:0] EEP_DUMMY  = 16'hBCBC;
  localparam logic [2:0]  SS_EEP     = 3'b100;
  localparam logic [1:0]  CH_RSVD    = 2'b11;

  // EEPROM read command word; sel picks offset (0) or gain (1).
  function automatic logic [15:0] cal_cmd(input logic [1:0] ch, input logic [2:0] gain,
                                          input logic sel);
    return {EEP_RD_CMD, ch, gain, sel, 8'h00};
  endfunction

endpackage

// File: rtl/circ_addr_ctr.sv
// Circular capture-RAM address counter: load next-after-value or increment, wrapping at Entries-1.
module circ_addr_ctr #(
  parameter int unsigned Entries = 384,
  parameter int unsigned AddrW   = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [AddrW-1:0] load_val_i,
  input  logic             inc_i,
  output logic [AddrW-1:0] addr_o
);

  localparam logic [AddrW-1:0] Last = AddrW'(Entries - 1);

  logic [AddrW-1:0] addr_d, addr_q;

  // A load starts at the entry following load_val_i (oldest sample after the newest).
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = (load_val_i == Last) ? '0 : load_val_i + AddrW'(1);
    end else if (inc_i) begin
      addr_d = (addr_q == Last) ? '0 : addr_q + AddrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) addr_q <= '0;
    else         addr_q <= addr_d;
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/dump_sequencer.sv
// Channel dump sequencer: EEPROM calibration reads, then a full circular RAM stream to the UART.
// Optional DUMP_CAL_CACHE_EN skips the EEPROM reads when channel and gain match the last calibration.
module dump_sequencer
  import dump_pkg::*;
#(
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump,
  input  logic [1:0]        dump_ch,
  input  logic [2:0]        ch1_AFEgain,
  input  logic [2:0]        ch2_AFEgain,
  input  logic [2:0]        ch3_AFEgain,
  input  logic [ADDR_W-1:0] trig_addr,
  input  logic              SPI_done,
  input  logic              resp_sent,
  output logic              wrt_SPI,
  output logic [15:0]       SPI_data,
  output logic [2:0]        ss,
  output logic              flopOffset,
  output logic              flopGain,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              send_resp,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] LastCnt = ADDR_W'(ENTRIES - 1);

  state_t            state_d, state_q;
  logic [1:0]        ch_d, ch_q;
  logic [2:0]        gain_d, gain_q;
  logic [ADDR_W-1:0] cnt_d, cnt_q;
  logic              phase_d, phase_q;
  logic              wrt_d, wrt_q;
  logic [15:0]       data_d, data_q;
  logic              send_d, send_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              addr_load, addr_inc;
  logic              flop_off, flop_gain;
  logic [2:0]        gain_mux;
  logic              cache_hit;

  always_comb begin
    unique case (dump_ch)
      2'b00:   gain_mux = ch1_AFEgain;
      2'b01:   gain_mux = ch2_AFEgain;
      2'b10:   gain_mux = ch3_AFEgain;
      default: gain_mux = 3'b000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    gain_d    = gain_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    data_d    = data_q;
    wrt_d     = 1'b0;
    send_d    = 1'b0;
    done_d    = 1'b0;
    addr_load = 1'b0;
    addr_inc  = 1'b0;
    flop_off  = 1'b0;
    flop_gain = 1'b0;
    case (state_q)
      StIdle: begin
        if (dump) begin
          ch_d      = dump_ch;
          gain_d    = gain_mux;
          cnt_d     = '0;
          phase_d   = 1'b0;
          addr_load = 1'b1;
          if (dump_ch == CH_RSVD) state_d = StDone;
          else if (cache_hit)     state_d = StRamRd;
          else                    state_d = StOffCmd;
        end
      end
      StOffCmd, StGainCmd: begin
        wrt_d   = 1'b1;
        data_d  = cal_cmd(ch_q, gain_q, state_q == StGainCmd);
        state_d = (state_q == StGainCmd) ? StGainRd : StOffRd;
      end
      // First SPI_done ends the command word; the second carries EEP_data.
      StOffRd, StGainRd: begin
        if (SPI_done) begin
          if (!phase_q) begin
            wrt_d   = 1'b1;
            data_d  = EEP_DUMMY;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (state_q == StOffRd) begin
              flop_off = 1'b1;
              state_d  = StGainCmd;
            end else begin
              flop_gain = 1'b1;
              state_d   = StRamRd;
            end
          end
        end
      end
      StRamRd: state_d = StSend;
      StSend: begin
        send_d  = 1'b1;
        state_d = StWaitTx;
      end
      StWaitTx: begin
        if (resp_sent) begin
          if (cnt_q == LastCnt) begin
            state_d = StDone;
          end else begin
            addr_inc = 1'b1;
            cnt_d    = cnt_q + ADDR_W'(1);
            state_d  = StRamRd;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ch_q    <= 2'b00;
      gain_q  <= 3'b000;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      wrt_q   <= 1'b0;
      data_q  <= 16'h0000;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      gain_q  <= gain_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      wrt_q   <= wrt_d;
      data_q  <= data_d;
      send_q  <= send_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef DUMP_CAL_CACHE_EN
  logic       cache_valid_d, cache_valid_q;
  logic [1:0] cache_ch_d, cache_ch_q;
  logic [2:0] cache_gain_d, cache_gain_q;

  assign cache_hit = cache_valid_q && (cache_ch_q == dump_ch) && (cache_gain_q == gain_mux);

  // Invalidate while a calibration is in flight so an abort never leaves a stale entry.
  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_ch_d    = cache_ch_q;
    cache_gain_d  = cache_gain_q;
    if (flop_gain) begin
      cache_valid_d = 1'b1;
      cache_ch_d    = ch_q;
      cache_gain_d  = gain_q;
    end else if (state_q == StOffCmd) begin
      cache_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid_q <= 1'b0;
      cache_ch_q    <= 2'b00;
      cache_gain_q  <= 3'b000;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_ch_q    <= cache_ch_d;
      cache_gain_q  <= cache_gain_d;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  circ_addr_ctr #(
    .Entries (ENTRIES),
    .AddrW   (ADDR_W)
  ) u_addr_ctr (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (addr_load),
    .load_val_i (trig_addr),
    .inc_i      (addr_inc),
    .addr_o     (ram_addr)
  );

  assign wrt_SPI    = wrt_q;
  assign SPI_data   = data_q;
  assign ss         = SS_EEP;
  assign flopOffset = flop_off;
  assign flopGain   = flop_gain;
  assign send_resp  = send_q;
  assign dump_busy  = busy_q;
  assign dump_done  = done_q;

endmodule

// File: tb/tb_dump_sequencer.sv
// Directed self-checking bench for dump_sequencer with behavioural SPI and UART responders.
module tb_dump_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dump = 1'b0;
  logic [1:0] dump_ch = 2'b00;
  logic [2:0] g1 = 3'b010, g2 = 3'b101, g3 = 3'b111;
  logic [8:0] trig_addr = 9'd0;
  logic       SPI_done = 1'b0;
  logic       resp_sent = 1'b0;
  logic       wrt_SPI, flopOffset, flopGain, send_resp, dump_busy, dump_done;
  logic [15:0] SPI_data;
  logic [2:0] ss;
  logic [8:0] ram_addr;

  int checks = 0, passes = 0;
  int n_send = 0, n_done = 0, bad_flop = 0, spi_cnt = 0, uart_cnt = 0;
  time t_dump = 0, t_done = 0;
  logic [15:0] spi_q[$];
  logic [8:0]  addr_q[$];
  int          ev_q[$];

  dump_sequencer #(.ENTRIES(384), .ADDR_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .dump(dump), .dump_ch(dump_ch),
    .ch1_AFEgain(g1), .ch2_AFEgain(g2), .ch3_AFEgain(g3), .trig_addr(trig_addr),
    .SPI_done(SPI_done), .resp_sent(resp_sent), .wrt_SPI(wrt_SPI), .SPI_data(SPI_data),
    .ss(ss), .flopOffset(flopOffset), .flopGain(flopGain), .ram_addr(ram_addr),
    .send_resp(send_resp), .dump_busy(dump_busy), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  // Monitor outputs mid-cycle, then update the responder inputs for the next cycle.
  always @(negedge clk) begin
    if (wrt_SPI) spi_q.push_back(SPI_data);
    if (flopOffset) begin ev_q.push_back(0); if (!SPI_done) bad_flop++; end
    if (flopGain) begin ev_q.push_back(1); if (!SPI_done) bad_flop++; end
    if (send_resp) begin n_send++; addr_q.push_back(ram_addr); end
    if (dump_done) begin n_done++; t_done = $time; end
    SPI_done = (spi_cnt == 1);
    if (spi_cnt > 0) spi_cnt--;
    if (wrt_SPI) spi_cnt = 3;
    resp_sent = (uart_cnt == 1);
    if (uart_cnt > 0) uart_cnt--;
    if (send_resp) uart_cnt = 2;
  end

  task automatic clear_logs();
    spi_q.delete(); addr_q.delete(); ev_q.delete();
    n_send = 0; n_done = 0; bad_flop = 0;
  endtask

  task automatic do_dump(input logic [1:0] ch, input logic [8:0] trig);
    @(negedge clk);
    dump_ch = ch; trig_addr = trig; dump = 1'b1; t_dump = $time;
    @(negedge clk);
    dump = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start = n_done;
    int k = 0;
    while (n_done == start && k < 5000) begin @(negedge clk); k++; end
    checks++;
    if (n_done == start) $display("FAIL %s_timeout: no dump_done within 5000 cycles", name);
    else passes++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (wrt_SPI !== 1'b0) $display("FAIL rst_wrt: got %b want 0", wrt_SPI); else passes++;
    checks++; if (SPI_data !== 16'h0000) $display("FAIL rst_data: got %h want 0000", SPI_data); else passes++;
    checks++; if (ss !== 3'b100) $display("FAIL rst_ss: got %b want 100", ss); else passes++;
    checks++; if ({flopOffset, flopGain} !== 2'b00) $display("FAIL rst_flop: got %b%b want 00", flopOffset, flopGain); else passes++;
    checks++; if (ram_addr !== 9'd0) $display("FAIL rst_addr: got %0d want 0", ram_addr); else passes++;
    checks++; if ({send_resp, dump_busy, dump_done} !== 3'b000) $display("FAIL rst_ctl: got %b%b%b want 000", send_resp, dump_busy, dump_done); else passes++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Dump ch2 with trig 383: calibration order and straight 0..383 sweep.
  task automatic test_cal_and_linear();
    int bad = 0;
    clear_logs();
    do_dump(2'b01, 9'd383);
    checks++; if (dump_busy !== 1'b1) $display("FAIL busy_rise: got %b want 1", dump_busy); else passes++;
    wait_done("linear");
    checks++; if (dump_busy !== 1'b0) $display("FAIL busy_fall: got %b want 0", dump_busy); else passes++;
    checks++; if (spi_q.size() !== 4) $display("FAIL spi_count: got %0d want 4", spi_q.size()); else passes++;
    if (spi_q.size() == 4) begin
      checks++;
      if (spi_q[0] !== 16'h1A00 || spi_q[1] !== 16'hBCBC || spi_q[2] !== 16'h1B00 || spi_q[3] !== 16'hBCBC)
        $display("FAIL spi_words: got %h %h %h %h want 1a00 bcbc 1b00 bcbc", spi_q[0], spi_q[1], spi_q[2], spi_q[3]);
      else passes++;
    end
    checks++;
    if (ev_q.size() != 2 || ev_q[0] != 0 || ev_q[1] != 1 || bad_flop != 0)
      $display("FAIL flop_order: got %0d pulses, %0d misaligned; want offset then gain", ev_q.size(), bad_flop);
    else passes++;
    checks++; if (n_send != 384) $display("FAIL linear_sends: got %0d want 384", n_send); else passes++;
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== 9'(i)) bad++;
    checks++; if (bad != 0) $display("FAIL linear_addr: got %0d wrong addresses want 0", bad); else passes++;
    checks++; if (n_done != 1) $display("FAIL linear_done: got %0d want 1", n_done); else passes++;
  endtask

  task automatic test_wrap();
    int bad = 0;
    clear_logs();
    do_dump(2'b00, 9'd100);
    wait_done("wrap");
    checks++;
    if (spi_q.size() != 4 || spi_q[0] !== 16'h0400 || spi_q[2] !== 16'h0500)
      $display("FAIL wrap_spi: got %0d words want 0400/0500 commands", spi_q.size());
    else passes++;
    checks++; if (n_send != 384) $display("FAIL wrap_sends: got %0d want 384", n_send); else passes++;
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== 9'((101 + i) % 384)) bad++;
    checks++; if (bad != 0) $display("FAIL wrap_addr: got %0d wrong addresses want 0", bad); else passes++;
    if (addr_q.size() > 0) begin
      checks++;
      if (addr_q[0] !== 9'd101 || addr_q[addr_q.size()-1] !== 9'd100)
        $display("FAIL wrap_ends: got %0d..%0d want 101..100", addr_q[0], addr_q[addr_q.size()-1]);
      else passes++;
    end
  endtask

  task automatic test_reserved();
    clear_logs();
    do_dump(2'b11, 9'd7);
    repeat (3) @(negedge clk);
    checks++; if (n_done != 1) $display("FAIL rsvd_done: got %0d want 1", n_done); else passes++;
    checks++; if (t_done - t_dump != 20) $display("FAIL rsvd_latency: got %0t want 20", t_done - t_dump); else passes++;
    checks++; if (spi_q.size() != 0 || n_send != 0) $display("FAIL rsvd_quiet: got %0d spi %0d sends want 0 0", spi_q.size(), n_send); else passes++;
  endtask

  task automatic test_back_to_back();
    int k = 0;
    clear_logs();
    do_dump(2'b10, 9'd5);
    while (n_send < 50 && k < 2000) begin @(negedge clk); k++; end
    g3 = 3'b000;
    do_dump(2'b00, 9'd200);
    wait_done("redump");
    g3 = 3'b111;
    checks++;
    if (spi_q.size() != 4 || spi_q[0] !== 16'h2E00 || spi_q[2] !== 16'h2F00)
      $display("FAIL redump_spi: got %0d words want 2e00/2f00 commands", spi_q.size());
    else passes++;
    checks++; if (n_send != 384) $display("FAIL redump_sends: got %0d want 384", n_send); else passes++;
    checks++; if (n_done != 1) $display("FAIL redump_done: got %0d want 1", n_done); else passes++;
    if (addr_q.size() > 0) begin
      checks++; if (addr_q[addr_q.size()-1] !== 9'd5) $display("FAIL redump_last: got %0d want 5", addr_q[addr_q.size()-1]); else passes++;
    end
  endtask

  task automatic test_abort();
    int k = 0;
    clear_logs();
    do_dump(2'b00, 9'd50);
    while (n_send < 10 && k < 2000) begin @(negedge clk); k++; end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({wrt_SPI, send_resp, dump_busy, dump_done} !== 4'b0000 || SPI_data !== 16'h0000 ||
        ram_addr !== 9'd0 || ss !== 3'b100)
      $display("FAIL abort_outputs: got busy=%b send=%b addr=%0d data=%h want reset values",
               dump_busy, send_resp, ram_addr, SPI_data);
    else passes++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (n_done != 0 || dump_busy !== 1'b0) $display("FAIL abort_no_done: got %0d dones busy=%b want 0 0", n_done, dump_busy); else passes++;
  endtask

  task automatic test_cache();
`ifdef DUMP_CAL_CACHE_EN
    int exp_two = 4;
`else
    int exp_two = 8;
`endif
    clear_logs();
    do_dump(2'b00, 9'd10);
    wait_done("cache1");
    do_dump(2'b00, 9'd10);
    wait_done("cache2");
    checks++; if (spi_q.size() != exp_two) $display("FAIL cache_same: got %0d spi want %0d", spi_q.size(), exp_two); else passes++;
    checks++; if (n_send != 768) $display("FAIL cache_sends: got %0d want 768", n_send); else passes++;
    g1 = 3'b011;
    do_dump(2'b00, 9'd10);
    wait_done("cache3");
    checks++; if (spi_q.size() != exp_two + 4) $display("FAIL cache_gain_chg: got %0d spi want %0d", spi_q.size(), exp_two + 4); else passes++;
    if (spi_q.size() >= 4) begin
      checks++; if (spi_q[spi_q.size()-4] !== 16'h0600) $display("FAIL cache_new_cmd: got %h want 0600", spi_q[spi_q.size()-4]); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_cal_and_linear();
    test_wrap();
    test_reserved();
    test_back_to_back();
    test_abort();
    test_cache();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
